// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
//   owner_e : the memory operation issued in the previous cycle. That cycle
//             is the ack cycle for this operation.
//   grant_e : which requester won the most recent issue. Used to alternate
//             between requesters when both are eligible.
//   MEM_AW / MEM_DW : default word-address and data widths.
package cpu_mem_pkg;

  localparam int MEM_AW = 10;
  localparam int MEM_DW = 32;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_INSTR  = 2'd1,
    OWN_DATA_R = 2'd2,
    OWN_DATA_W = 2'd3
  } owner_e;

  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets the instruction-fetch port and the load/store port share one
// single-port synchronous RAM. The arbiter issues at most one memory
// operation per cycle. In the following cycle it acks that operation and
// returns the read data.
//
// Ports
//   CLK, RSTn            clock (rising edge), asynchronous active-low reset
//   i_req, iaddr         fetch request (level) and word address
//   idata, i_ack         fetch read data and one-cycle completion pulse
//   d_r, d_w             load / store request (level)
//   daddr, ddata_w       data word address and store data
//   ddata_r, d_ack       load read data and one-cycle completion pulse
//   stall                pipeline hold while any request is unacked
//   err                  sticky flag: load and store requested together
//   mem_addr, mem_wdata  RAM address / write data
//   mem_we, mem_re       RAM write / read enables
//   mem_rdata            RAM read data, valid the cycle after mem_re
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          i_req,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  output logic          i_ack,
  input  logic          d_r,
  input  logic          d_w,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] ddata_w,
  output logic [DW-1:0] ddata_r,
  output logic          d_ack,
  output logic          stall,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  owner_e        owner_q, owner_d;
  grant_e        last_grant_q, last_grant_d;
  logic [DW-1:0] idata_q;
  logic [DW-1:0] ddata_q;
  logic          err_q, err_d;

  logic          fetch_elig;
  logic          data_elig;
  logic          grant_data;
  logic          grant_fetch;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;
  logic          re_c;
  logic          we_c;

  always_comb begin
    owner_d      = OWN_NONE;
    last_grant_d = last_grant_q;
    addr_c       = '0;
    wdata_c      = '0;
    re_c         = 1'b0;
    we_c         = 1'b0;

    // A requester cannot be re-issued in its own ack cycle. This blocking
    // gives the other requester the free slot.
    fetch_elig  = i_req && (owner_q != OWN_INSTR);
    data_elig   = (d_r || d_w) && (owner_q != OWN_DATA_R) && (owner_q != OWN_DATA_W);

    // Data wins ties unless data also won the previous issue.
    grant_data  = data_elig && (!fetch_elig || (last_grant_q != GNT_DATA));
    grant_fetch = fetch_elig && !grant_data;

    if (grant_data) begin
      last_grant_d = GNT_DATA;
      addr_c       = daddr;
      // d_r and d_w both high counts as a store.
      if (d_w) begin
        we_c    = 1'b1;
        wdata_c = ddata_w;
        owner_d = OWN_DATA_W;
      end else begin
        re_c    = 1'b1;
        owner_d = OWN_DATA_R;
      end
    end else if (grant_fetch) begin
      last_grant_d = GNT_INSTR;
      addr_c       = iaddr;
      re_c         = 1'b1;
      owner_d      = OWN_INSTR;
    end

    err_d = err_q || (d_r && d_w);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      owner_q      <= OWN_NONE;
      last_grant_q <= GNT_INSTR;
      idata_q      <= '0;
      ddata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      // Capture the read data at the end of the ack cycle. The output then
      // keeps that value until the next read for the same port completes.
      if (owner_q == OWN_INSTR) begin
        idata_q <= mem_rdata;
      end
      if (owner_q == OWN_DATA_R) begin
        ddata_q <= mem_rdata;
      end
    end
  end

  // Reset masks the RAM interface immediately. A store caught in its issue
  // cycle never reaches the RAM.
  assign mem_re    = re_c && RSTn;
  assign mem_we    = we_c && RSTn;
  assign mem_addr  = RSTn ? addr_c  : '0;
  assign mem_wdata = RSTn ? wdata_c : '0;

  assign i_ack   = (owner_q == OWN_INSTR);
  assign d_ack   = (owner_q == OWN_DATA_R) || (owner_q == OWN_DATA_W);
  assign idata   = (owner_q == OWN_INSTR)  ? mem_rdata : idata_q;
  assign ddata_r = (owner_q == OWN_DATA_R) ? mem_rdata : ddata_q;
  assign err     = err_q;
  assign stall   = (i_req && !i_ack) || ((d_r || d_w) && !d_ack);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous RAM between the core's instruction-fetch port and its data load/store port. Each cycle it issues at most one memory operation. It returns the read data and a one-cycle ack to the requester that owns the operation, and drives a stall to the pipeline while any request is pending. It sits between the pipelined core and the unified instruction/data memory.

Parameters:
AW, 10, word-address width (byte address bits [11:2])
DW, 32, data width

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  asynchronous active-low reset
i_req  in  1  fetch request, level, held until i_ack
iaddr  in  AW  fetch word address
idata  out  DW  fetch read data
i_ack  out  1  fetch complete, one-cycle pulse
d_r  in  1  load request, level, held until d_ack
d_w  in  1  store request, level, held until d_ack
daddr  in  AW  data word address
ddata_w  in  DW  store data
ddata_r  out  DW  load read data
d_ack  out  1  data op complete, one-cycle pulse
stall  out  1  pipeline hold
err  out  1  sticky: d_r and d_w seen high together
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_we  out  1  RAM write enable
mem_re  out  1  RAM read enable
mem_rdata  in  DW  RAM read data, valid the cycle after mem_re

Behaviour:
- Reset values: i_ack=0, d_ack=0, idata=0, ddata_r=0, err=0, owner=NONE, last_grant=INSTR.
- While RSTn=0, mem_we and mem_re are forced to 0 asynchronously.
- Owner register values: NONE / INSTR / DATA_R / DATA_W. It records the op issued in the previous cycle.
- Eligibility in a cycle:
  - Fetch is eligible when i_req=1 and owner!=INSTR.
  - Data is eligible when (d_r|d_w)=1 and owner is not DATA_R or DATA_W.
  - A requester is therefore never re-issued in its own ack cycle. Its earliest next issue is the cycle after the ack.
- Selection:
  - Only one eligible requester: grant it.
  - Both eligible: grant data, unless last_grant=DATA, in which case grant fetch.
  - last_grant updates on every issue.
- Issue cycle N (combinational mem signals from the granted requester):
  - Fetch: mem_addr=iaddr, mem_re=1.
  - Load: mem_addr=daddr, mem_re=1.
  - Store: mem_addr=daddr, mem_wdata=ddata_w, mem_we=1.
  - No grant: mem_re=mem_we=0, mem_addr=0, mem_wdata=0.
  - At the edge ending cycle N, owner takes the issued op type, or NONE if nothing was issued.
- Ack cycle N+1:
  - Owner INSTR: i_ack=1, idata=mem_rdata (combinational pass-through).
  - Owner DATA_R: d_ack=1, ddata_r=mem_rdata (combinational pass-through).
  - Owner DATA_W: d_ack=1, ddata_r is unchanged.
  - On the edge ending the ack cycle, mem_rdata is captured into the matching hold register. idata/ddata_r then hold that value until the next read for that port completes.
- Latency: 1 cycle from issue to ack when uncontended.
- Throughput:
  - Both requesters continuously active: the arbiter interleaves them, 1 op per cycle total.
  - Single requester: 1 op per 2 cycles.
- stall = (i_req & ~i_ack) | ((d_r|d_w) & ~d_ack). Combinational, no reset value beyond its inputs.
- d_r=1 and d_w=1 together:
  - The op is treated as a store.
  - err is set on the next edge and stays set until reset.
- Address or data changes while a request is pending and not yet issued: the values in the issue cycle are used.
- Request dropped before issue: it is never issued and never acked.
- Request dropped in the ack cycle: legal, no effect.
- Reset asserted mid-operation:
  - The outstanding op is discarded with no ack.
  - A store in its issue cycle is suppressed by the mem_we gating.
  - Hold registers clear to 0.

Decomposition:
- Package cpu_mem_pkg:
  - owner_e enum (NONE, INSTR, DATA_R, DATA_W), 2 bits.
  - grant_e enum (INSTR, DATA), 1 bit.
  - Constants MEM_AW=10, MEM_DW=32.
- Single module; no sub-module is warranted. Arbitration, owner register and the two hold registers stay in one always_ff plus one always_comb.

Test Plan:
- Reset, then i_req=1, iaddr=0x004, RAM[4]=0x00500093 -> mem_re=1 and mem_addr=0x004 in cycle 1; i_ack=1 and idata=0x00500093 in cycle 2; stall=1 in cycle 1, stall=0 in cycle 2.
- i_req and d_r both high from reset; daddr=0x010, iaddr=0x000 -> grant order DATA(0x010), INSTR(0x000), DATA, INSTR. Exactly one mem_re per cycle, with d_ack and i_ack alternating.
- d_w=1, daddr=0x020, ddata_w=0xDEADBEEF, then d_r at 0x020 -> mem_we=1 for one cycle, d_ack the next cycle; the following load returns ddata_r=0xDEADBEEF.
- d_r=d_w=1, daddr=0x030, ddata_w=0x12345678 -> store performed, err=1 on the next edge and still 1 after 10 idle cycles; a subsequent RSTn pulse clears err.
- RSTn driven low in a store's issue cycle -> mem_we=0 immediately, d_ack never asserted, RAM[0x030] unchanged, all outputs 0.
- Load completes with 0xA5A5A5A5, then 5 idle cycles with mem_rdata randomised -> ddata_r stays 0xA5A5A5A5 throughout.
